counter_sequencer: RTL
======================

# counter_sequencer

Command-driven controller that sequences the team's parameterised up/down counter (`paramCounter`). It accepts one command at a time over a valid/ready handshake, optionally preloads the counter, then steps it up or down for a programmed number of cycles. It reports the final count with a one-cycle done pulse. The block sits between a host/CSR interface and a `paramCounter` instance and is the only driver of that counter's `rst`, `up`, `down` and `initial_value` inputs.

## Interface
- `WIDTH`, 8, counter width; must match the attached `paramCounter`.
- `LEN_W`, 8, width of the step-length field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_load` in 1: preload counter with `cmd_start` before stepping.
- `cmd_dir` in 1: 1 = count up, 0 = count down.
- `cmd_start` in WIDTH: preload value.
- `cmd_len` in LEN_W: number of step cycles (0 is legal).
- `abort` in 1: synchronous abort of the current command.
- `cnt_value` in WIDTH: `count` output of the counter.
- `cnt_load` out 1: drives counter `rst`; loads `cnt_init`.
- `cnt_init` out WIDTH: drives counter `initial_value`.
- `cnt_up` out 1: drives counter `up`.
- `cnt_down` out 1: drives counter `down`.
- `busy` out 1: command in progress (any state except IDLE).
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: qualifies `done`; command was cut short.
- `result` out WIDTH: counter value captured in DONE; holds until the next DONE.

## Operation
- FSM states are IDLE, LOAD, RUN and DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `dir`, `start` and `len` into `rem`.
  - Next state is LOAD if `cmd_load`, else RUN if `len`≠0, else DONE.
- **LOAD**
  - Lasts exactly one cycle.
  - `cnt_load`=1 and `cnt_init`=latched `start`.
  - Next state is RUN if `rem`≠0, else DONE.
- **RUN**
  - Assert `cnt_up` (dir=1) or `cnt_down` (dir=0) combinationally every cycle.
  - Decrement `rem` each cycle; leave for DONE when `rem`==1.
  - `cnt_up` and `cnt_down` are never asserted together.
- **DONE**
  - Lasts one cycle.
  - `done`=1 and `result`←`cnt_value`, which already reflects the last step.
  - Next state is IDLE.
- Outside LOAD: `cnt_load`=0 and `cnt_init`=0.
- `cmd_ready`=0 in every state except IDLE; commands presented then are held off and not lost.
- `abort` in LOAD or RUN:
  - Deassert all counter controls that same cycle.
  - Go to DONE with `aborted`=1.
  - Steps already taken stand.
- `abort` in IDLE or DONE is ignored.
- Counter arithmetic wraps modulo 2^WIDTH unless the bound feature is compiled in.
- `rst_n` low mid-command:
  - State returns to IDLE immediately.
  - All outputs go to reset values.
  - No `done` pulse.
- Reset values:
  - `cmd_ready`=1.
  - `busy`, `done`, `aborted`, `cnt_load`, `cnt_up`, `cnt_down`=0.
  - `cnt_init`, `result`=0.

## Timing
- Command accepted at edge T.
- With `cmd_load`:
  - LOAD occupies T..T+1; the counter holds `start` after edge T+1.
  - RUN lasts `len` cycles.
  - `done` is high in cycle T+1+`len`+1.
  - `result` = `start`±`len`.
- Without `cmd_load`:
  - RUN starts the cycle after acceptance.
  - `done` is high `len`+1 cycles after acceptance.
- `len`=0: DONE follows acceptance (or LOAD) directly.
- Earliest next acceptance is the cycle after DONE, i.e. one idle cycle between commands.

## Configuration
- `COUNTER_SEQ_BOUND_EN` defined:
  - In RUN, if dir=1 and `cnt_value`==2^WIDTH−1, or dir=0 and `cnt_value`==0, suppress the step that cycle.
  - Go to DONE with `aborted`=1 (saturating stop).
- `COUNTER_SEQ_BOUND_EN` undefined: no check; the counter wraps.

## Structure
- Shared package `counter_seq_pkg`:
  - State enum `seq_state_t` (IDLE, LOAD, RUN, DONE).
  - Default `WIDTH`/`LEN_W` constants.
- No sub-module inside the block.
- The integration top instantiates `counter_sequencer` alongside `paramCounter`.

## Test plan
- Load 8'h08, up, len=5 -> `cnt_load` for 1 cycle; `cnt_up` for 5 cycles; `done` with `result`=13, `aborted`=0.
- No load from count 13, down, len=5 -> `result`=8; `cnt_down` high exactly 5 cycles; `done` 6 cycles after accept.
- Load 8'h10, len=0 -> `done` the cycle after LOAD; `result`=16; no `cnt_up`/`cnt_down`.
- `abort` on the 3rd RUN cycle of up len=10 from 0 -> `done`+`aborted` next cycle; `result`=2.
- Load 8'hFE, up, len=4 -> without macro `result`=2 (wrap); with `COUNTER_SEQ_BOUND_EN` `result`=8'hFF and `aborted`=1.
- `rst_n` low mid-RUN plus back-to-back commands -> outputs at reset values, no `done`; second command only accepted after first `done`+1 cycle.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared types and defaults for the counter sequencer.
//   seq_state_t   : sequencer FSM state encoding (IDLE, LOAD, RUN, DONE)
//   SEQ_WIDTH_DEF : default counter width
//   SEQ_LEN_W_DEF : default step-length field width
package counter_seq_pkg;

  localparam int unsigned SEQ_WIDTH_DEF = 8;
  localparam int unsigned SEQ_LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Command-driven controller for an external up/down counter (paramCounter).
// Accepts one command over valid/ready, optionally preloads the counter,
// steps it up or down for cmd_len cycles, then pulses done with the final
// count captured into result.
//
// Optional feature: define COUNTER_SEQ_BOUND_EN to stop at the counter
// limits (all-ones going up, zero going down) instead of wrapping; the stop
// is reported as an aborted completion.
//
// Ports
//   clk, rst_n                : clock, async active-low reset
//   cmd_valid / cmd_ready     : command handshake
//   cmd_load, cmd_dir         : preload enable, direction (1 = up)
//   cmd_start, cmd_len        : preload value, number of step cycles
//   abort                     : cut the current command short (LOAD/RUN only)
//   cnt_value                 : counter count output
//   cnt_load, cnt_init        : counter rst / initial_value
//   cnt_up, cnt_down          : counter step controls
//   busy, done, aborted       : status; done is a one-cycle pulse
//   result                    : count captured in DONE, held until next DONE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command
// LOAD  | one cycle driving cnt_load / cnt_init with the latched start
// RUN   | one counter step per cycle until rem reaches its last step
// DONE  | one-cycle done pulse, result captured from cnt_value
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH_DEF,
  parameter int unsigned LEN_W = SEQ_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_init,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  seq_state_t       state, state_nxt;
  logic             dir_q;
  logic [WIDTH-1:0] start_q;
  logic [LEN_W-1:0] rem_q;
  logic             aborted_q;
  logic [WIDTH-1:0] result_q;
  logic             accept;
  logic             stop;
  logic             at_bound;

  assign accept = (state == IDLE) && cmd_valid;

`ifdef COUNTER_SEQ_BOUND_EN
  // Taking another step from here would wrap the counter.
  assign at_bound = dir_q ? (cnt_value == {WIDTH{1'b1}}) : (cnt_value == '0);
`else
  assign at_bound = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      start_q   <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dir_q     <= cmd_dir;
        start_q   <= cmd_start;
        rem_q     <= cmd_len;
        aborted_q <= 1'b0;
      end else begin
        if (state == RUN) begin
          rem_q <= rem_q - LEN_W'(1);
        end
        if (stop) begin
          aborted_q <= 1'b1;
        end
      end
      if (state == DONE) begin
        result_q <= cnt_value;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_init  = '0;
    cnt_up    = 1'b0;
    cnt_down  = 1'b0;
    stop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            state_nxt = LOAD;
          end else if (cmd_len != '0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          stop      = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_load  = 1'b1;
          cnt_init  = start_q;
          state_nxt = (rem_q != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort and the bound stop both withhold this cycle's step.
        if (abort || at_bound) begin
          stop      = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_up   = dir_q;
          cnt_down = !dir_q;
          if (rem_q == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign aborted   = (state == DONE) && aborted_q;
  assign result    = result_q;

endmodule
